// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers (radix-2 shift-add / restoring divide).
// Optional MULDIV_FAST_ZERO_EN: zero multiply operand or zero divisor skips the iteration phase.
module mult_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ALUin2,
  input  logic              HIwrite,
  input  logic              LOwrite,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              Busy,
  output logic              Done,
  output logic              DivByZero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic                op_div, res_neg, rem_neg, dbz;
  logic [DATA_W-1:0]   opnd, a_raw, w_hi, w_lo;

  // Op[1] selects divide, Op[0] selects unsigned
  logic                op_signed, a_neg, b_neg, fast_zero, last_calc, fix_wb;
  logic [DATA_W-1:0]   a_mag, b_mag;

  assign op_signed = ~Op[0];
  assign a_neg     = op_signed & ReadData1[DATA_W-1];
  assign b_neg     = op_signed & ALUin2[DATA_W-1];
  assign a_mag     = a_neg ? -ReadData1 : ReadData1;
  assign b_mag     = b_neg ? -ALUin2 : ALUin2;
  assign last_calc = (cnt == CNT_W'(DATA_W-1));
  assign fix_wb    = (cnt != '0);

`ifdef MULDIV_FAST_ZERO_EN
  assign fast_zero = Op[1] ? (ALUin2 == '0) : ((ReadData1 == '0) || (ALUin2 == '0));
`else
  assign fast_zero = 1'b0;
`endif

  // One iteration of each algorithm; w_lo holds multiplier / shifting quotient
  logic [DATA_W:0]     mul_sum, div_shift;
  logic                div_ge;
  logic [DATA_W-1:0]   div_diff;
  logic [2*DATA_W-1:0] prod_neg;

  assign mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {w_hi, w_lo[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[DATA_W-1:0] - opnd;
  assign prod_neg  = -{w_hi, w_lo};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = fast_zero ? FIX : CALC;
      CALC:    if (last_calc) state_nxt = FIX;
      FIX:     if (fix_wb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      op_div    <= 1'b0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      dbz       <= 1'b0;
      opnd      <= '0;
      a_raw     <= '0;
      w_hi      <= '0;
      w_lo      <= '0;
      HI        <= '0;
      LO        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Busy      <= (state_nxt != IDLE);
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_div  <= Op[1];
            res_neg <= a_neg ^ b_neg;
            rem_neg <= Op[1] & a_neg;
            dbz     <= Op[1] & (ALUin2 == '0);
            a_raw   <= ReadData1;
            opnd    <= Op[1] ? b_mag : a_mag;
            w_hi    <= '0;
            w_lo    <= fast_zero ? '0 : (Op[1] ? a_mag : b_mag);
            cnt     <= '0;
          end else begin
            if (HIwrite) HI <= WriteData;
            if (LOwrite) LO <= WriteData;
          end
        end
        CALC: begin
          if (op_div) begin
            w_hi <= div_ge ? div_diff : div_shift[DATA_W-1:0];
            w_lo <= {w_lo[DATA_W-2:0], div_ge};
          end else begin
            w_hi <= mul_sum[DATA_W:1];
            w_lo <= {mul_sum[0], w_lo[DATA_W-1:1]};
          end
          cnt <= last_calc ? '0 : cnt + CNT_W'(1);
        end
        FIX: begin
          // First FIX cycle corrects signs in place, second one writes HI/LO
          if (!fix_wb) begin
            if (op_div && dbz) begin
              w_hi <= a_raw;
              w_lo <= '1;
            end else if (op_div) begin
              w_lo <= res_neg ? -w_lo : w_lo;
              w_hi <= rem_neg ? -w_hi : w_hi;
            end else if (res_neg) begin
              {w_hi, w_lo} <= prod_neg;
            end
            cnt <= CNT_W'(1);
          end else begin
            HI        <= w_hi;
            LO        <= w_lo;
            Done      <= 1'b1;
            DivByZero <= dbz;
            cnt       <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
